// File: rtl/seg_pkg.sv
// seg_capture shared types: active-high segment patterns (a..g)
// and the capture FSM state encoding.
package seg_pkg;

  localparam logic [0:6] SEG_0     = 7'b1111110;
  localparam logic [0:6] SEG_1     = 7'b0110000;
  localparam logic [0:6] SEG_2     = 7'b1101101;
  localparam logic [0:6] SEG_3     = 7'b1111001;
  localparam logic [0:6] SEG_4     = 7'b0110011;
  localparam logic [0:6] SEG_5     = 7'b1011011;
  localparam logic [0:6] SEG_6     = 7'b1011111;
  localparam logic [0:6] SEG_7     = 7'b1110000;
  localparam logic [0:6] SEG_8     = 7'b1111111;
  localparam logic [0:6] SEG_9     = 7'b1111011;
  localparam logic [0:6] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    HOLD
  } cap_state_t;

endpackage

// File: rtl/seg_to_bcd.sv
// Combinational decode of an active-low 7-segment pattern
// into a BCD digit, blank flag or illegal flag.
module seg_to_bcd
  import seg_pkg::*;
(
  input  logic [0:6] seg_n_i,
  output logic [3:0] digit_o,
  output logic       is_blank_o,
  output logic       is_illegal_o
);

  logic [0:6] seg;
  assign seg = ~seg_n_i;

  always_comb begin
    digit_o      = 4'd0;
    is_blank_o   = 1'b0;
    is_illegal_o = 1'b0;
    unique case (1'b1)
      (seg == SEG_0):     digit_o = 4'd0;
      (seg == SEG_1):     digit_o = 4'd1;
      (seg == SEG_2):     digit_o = 4'd2;
      (seg == SEG_3):     digit_o = 4'd3;
      (seg == SEG_4):     digit_o = 4'd4;
      (seg == SEG_5):     digit_o = 4'd5;
      (seg == SEG_6):     digit_o = 4'd6;
      (seg == SEG_7):     digit_o = 4'd7;
      (seg == SEG_8):     digit_o = 4'd8;
      (seg == SEG_9):     digit_o = 4'd9;
      (seg == SEG_BLANK): is_blank_o = 1'b1;
      default:            is_illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_capture.sv
// Reconstructs BCD digits from a multiplexed active-low 7-seg bus,
// capturing each position once its inputs have been stable.
module seg_capture
  import seg_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int STABLE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [0:6]            seg_in,
  input  logic [DIGITS-1:0]     dig_sel_n,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     blank,
  output logic                  frame_valid,
  output logic                  err,
  output logic [2:0]            err_digit
);

  localparam int         SW   = 7 + DIGITS;
  localparam logic [7:0] STAB = 8'(STABLE);

  cap_state_t state_q, state_d;

  logic [SW-1:0]       samp_q, samp_d;
  logic [7:0]          stab_q, stab_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic [DIGITS-1:0]   seen_q, seen_d;
  logic                fv_q, fv_d;
  logic                err_q, err_d;
  logic [2:0]          errd_q, errd_d;

  logic                chg;
  logic                cur_one;
  logic [DIGITS-1:0]   sel_q;
  logic [2:0]          idx;
  logic [3:0]          dig;
  logic                is_blank;
  logic                is_ill;

  assign samp_d  = {seg_in, dig_sel_n};
  assign chg     = samp_d != samp_q;
  assign cur_one = $countones(~dig_sel_n) == 1;
  assign sel_q   = samp_q[DIGITS-1:0];

  seg_to_bcd u_dec (
    .seg_n_i      (samp_q[SW-1:DIGITS]),
    .digit_o      (dig),
    .is_blank_o   (is_blank),
    .is_illegal_o (is_ill)
  );

  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < DIGITS; i++)
      if (!sel_q[i]) idx = 3'(i);
  end

  always_comb begin
    stab_d = stab_q;
    if (clear)            stab_d = 8'd0;
    else if (chg)         stab_d = 8'd1;
    else if (stab_q < STAB) stab_d = stab_q + 8'd1;
  end

  // SETTLE looks at the count being written this edge so the
  // capture cycle starts right after the STABLE-th sample.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cur_one) state_d = SETTLE;
      SETTLE: begin
        if (!cur_one)            state_d = IDLE;
        else if (stab_d == STAB) state_d = CAPTURE;
      end
      CAPTURE: state_d = HOLD;
      HOLD:    if (chg) state_d = cur_one ? SETTLE : IDLE;
      default: state_d = IDLE;
    endcase
    if (clear) state_d = HOLD;
  end

  always_comb begin
    bcd_d   = bcd_q;
    blank_d = blank_q;
    seen_d  = seen_q;
    err_d   = err_q;
    errd_d  = errd_q;
    fv_d    = 1'b0;
    if (clear) begin
      err_d  = 1'b0;
      errd_d = 3'd0;
      seen_d = '0;
    end else begin
      if (state_q == CAPTURE) begin
        if (is_ill) begin
          err_d  = 1'b1;
          errd_d = idx;
        end else begin
          for (int i = 0; i < DIGITS; i++) begin
            if (!sel_q[i]) begin
              seen_d[i]  = 1'b1;
              blank_d[i] = is_blank;
              if (!is_blank) bcd_d[4*i +: 4] = dig;
            end
          end
        end
      end
      if (&seen_d) begin
        fv_d   = 1'b1;
        seen_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      samp_q  <= '1;
      stab_q  <= 8'd0;
      bcd_q   <= '0;
      blank_q <= '1;
      seen_q  <= '0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
      errd_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      stab_q  <= stab_d;
      bcd_q   <= bcd_d;
      blank_q <= blank_d;
      seen_q  <= seen_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
      errd_q  <= errd_d;
    end
  end

  assign bcd_out     = bcd_q;
  assign blank       = blank_q;
  assign frame_valid = fv_q;
  assign err         = err_q;
  assign err_digit   = errd_q;

endmodule

// File: tb/tb_seg_capture.sv
// Directed bench for seg_capture: scan frames, glitch rejection,
// illegal patterns, clear, multi-select and async reset.
module tb_seg_capture;
  import seg_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:6]  seg_in;
  logic [3:0]  dig_sel_n;
  logic        clear;
  logic [15:0] bcd_out;
  logic [3:0]  blank;
  logic        frame_valid;
  logic        err;
  logic [2:0]  err_digit;

  int checks   = 0;
  int failures = 0;
  int fv_cnt   = 0;

  seg_capture #(
    .DIGITS (4),
    .STABLE (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .dig_sel_n   (dig_sel_n),
    .clear       (clear),
    .bcd_out     (bcd_out),
    .blank       (blank),
    .frame_valid (frame_valid),
    .err         (err),
    .err_digit   (err_digit)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (frame_valid) fv_cnt++;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [0:6] pat, input logic [3:0] sel);
    seg_in    = ~pat;
    dig_sel_n = sel;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    put(SEG_BLANK, 4'b1111);
    #12;
    chk("rst_bcd",  32'(bcd_out), 32'h0);
    chk("rst_blank", 32'(blank), 32'hf);
    chk("rst_fv",   32'(frame_valid), 32'h0);
    chk("rst_err",  32'(err), 32'h0);
    chk("rst_errd", 32'(err_digit), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);

    put(SEG_1, 4'b1110); cyc(8);
    put(SEG_2, 4'b1101); cyc(8);
    put(SEG_3, 4'b1011); cyc(8);
    chk("fv_none_yet", 32'(fv_cnt), 32'd0);
    put(SEG_4, 4'b0111); cyc(4);
    chk("d3_pre", 32'(bcd_out[15:12]), 32'h0);
    chk("fv_pre", 32'(frame_valid), 32'h0);
    cyc(1);
    chk("d3_upd", 32'(bcd_out[15:12]), 32'h4);
    chk("fv_pulse", 32'(frame_valid), 32'h1);
    cyc(1);
    chk("fv_drop", 32'(frame_valid), 32'h0);
    cyc(2);
    chk("frame1_bcd", 32'(bcd_out), 32'h4321);
    chk("frame1_blank", 32'(blank), 32'h0);
    chk("frame1_err", 32'(err), 32'h0);
    chk("frame1_fvcnt", 32'(fv_cnt), 32'd1);

    put(SEG_5, 4'b1110); cyc(3);
    put(SEG_5, 4'b1111); cyc(3);
    chk("glitch_bcd", 32'(bcd_out[3:0]), 32'h1);
    chk("glitch_err", 32'(err), 32'h0);
    put(SEG_5, 4'b1110); cyc(4);
    chk("d0_k3", 32'(bcd_out[3:0]), 32'h1);
    cyc(1);
    chk("d0_k4", 32'(bcd_out[3:0]), 32'h5);
    cyc(3);

    put(7'b0000001, 4'b1011); cyc(8);
    chk("ill_err", 32'(err), 32'h1);
    chk("ill_errd", 32'(err_digit), 32'h2);
    chk("ill_bcd", 32'(bcd_out[11:8]), 32'h3);
    put(SEG_7, 4'b1101); cyc(8);
    put(SEG_9, 4'b0111); cyc(8);
    chk("ill_nofv", 32'(fv_cnt), 32'd1);
    chk("ill_bcd_all", 32'(bcd_out), 32'h9375);
    clear = 1'b1; cyc(1); clear = 1'b0;
    chk("clr_err", 32'(err), 32'h0);
    chk("clr_errd", 32'(err_digit), 32'h0);

    put(SEG_8, 4'b1011); cyc(4);
    clear = 1'b1; cyc(1); clear = 1'b0;
    chk("clr_cap_bcd", 32'(bcd_out[11:8]), 32'h3);
    cyc(3);
    chk("no_recap", 32'(bcd_out[11:8]), 32'h3);

    put(SEG_8, 4'b1100); cyc(20);
    chk("multi_idle", 32'(dut.state_q), 32'(IDLE));
    chk("multi_bcd", 32'(bcd_out), 32'h9375);
    chk("multi_fv", 32'(fv_cnt), 32'd1);
    chk("multi_err", 32'(err), 32'h0);

    put(SEG_0, 4'b1110); cyc(8);
    put(SEG_BLANK, 4'b1101); cyc(8);
    chk("blank_bit", 32'(blank), 32'h2);
    chk("blank_keep", 32'(bcd_out[7:4]), 32'h7);
    put(SEG_6, 4'b1011); cyc(8);
    put(SEG_2, 4'b0111); cyc(8);
    chk("blank_frame", 32'(fv_cnt), 32'd2);
    chk("frame2_bcd", 32'(bcd_out), 32'h2670);
    chk("frame2_blank", 32'(blank), 32'h2);

    put(SEG_3, 4'b1110); cyc(2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bcd", 32'(bcd_out), 32'h0);
    chk("arst_blank", 32'(blank), 32'hf);
    chk("arst_fv", 32'(frame_valid), 32'h0);
    chk("arst_err", 32'(err), 32'h0);
    cyc(6);
    chk("arst_hold", 32'(bcd_out), 32'h0);
    rst_n = 1'b1;
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
